// File: rtl/digi_ota_cal_seq.sv
// Offset-calibration sequencer for the digital OTA: shorts the OTA inputs, runs a
// SAR search on the trim code from averaged comparator decisions, then holds the code.
module digi_ota_cal_seq #(
   parameter int TRIM_W     = 6,
   parameter int SETTLE_CYC = 16,
   parameter int AVG_CYC    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              cmp_in,
   output logic [TRIM_W-1:0] trim_code,
   output logic              short_en,
   output logic              busy,
   output logic              done,
   output logic              cal_err
);

   localparam int MAX_CYC = (SETTLE_CYC > AVG_CYC) ? SETTLE_CYC : AVG_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC);
   localparam int ONES_W  = $clog2(AVG_CYC) + 1;
   localparam int IDX_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
   localparam logic [TRIM_W-1:0] MID_CODE = TRIM_W'(1) << (TRIM_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_DECIDE  = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t state, state_d;

   logic [CNT_W-1:0]  cyc_cnt, cyc_cnt_d;
   logic [ONES_W-1:0] ones_cnt, ones_cnt_d;
   logic [IDX_W-1:0]  bit_idx, bit_idx_d;
   logic [TRIM_W-1:0] trim_d, trial_code;
   logic              short_d, busy_d, done_d, err_d;

   // start and abort are single-cycle strobes sampled on the rising edge; no
   // handshake back to the requester other than the busy/done levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cyc_cnt   <= '0;
         ones_cnt  <= '0;
         bit_idx   <= '0;
         trim_code <= MID_CODE;
         short_en  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cal_err   <= 1'b0;
      end else begin
         state     <= state_d;
         cyc_cnt   <= cyc_cnt_d;
         ones_cnt  <= ones_cnt_d;
         bit_idx   <= bit_idx_d;
         trim_code <= trim_d;
         short_en  <= short_d;
         busy      <= busy_d;
         done      <= done_d;
         cal_err   <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_d = ST_SETTLE;
         ST_SETTLE: begin
            if (abort)                                     state_d = ST_IDLE;
            else if (cyc_cnt == CNT_W'(SETTLE_CYC - 1))    state_d = ST_MEASURE;
         end
         ST_MEASURE: begin
            if (abort)                                     state_d = ST_IDLE;
            else if (cyc_cnt == CNT_W'(AVG_CYC - 1))       state_d = ST_DECIDE;
         end
         ST_DECIDE: begin
            if (abort)               state_d = ST_IDLE;
            else if (bit_idx == '0)  state_d = ST_DONE;
            else                     state_d = ST_SETTLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Trial result: drop the bit under test on a tie or majority-low vote,
   // then arm the next lower bit if any remain.
   always_comb begin
      trial_code = trim_code;
      if (ones_cnt <= ONES_W'(AVG_CYC / 2)) trial_code[bit_idx] = 1'b0;
      if (bit_idx != '0) trial_code[bit_idx - IDX_W'(1)] = 1'b1;
   end

   always_comb begin
      cyc_cnt_d  = cyc_cnt;
      ones_cnt_d = ones_cnt;
      bit_idx_d  = bit_idx;
      trim_d     = trim_code;
      short_d    = short_en;
      busy_d     = busy;
      done_d     = done;
      err_d      = cal_err;
      if (state_d == ST_IDLE && state != ST_IDLE) begin
         cyc_cnt_d  = '0;
         ones_cnt_d = '0;
         bit_idx_d  = '0;
         trim_d     = MID_CODE;
         short_d    = 1'b0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  cyc_cnt_d  = '0;
                  ones_cnt_d = '0;
                  bit_idx_d  = IDX_W'(TRIM_W - 1);
                  trim_d     = MID_CODE;
                  short_d    = 1'b1;
                  busy_d     = 1'b1;
                  done_d     = 1'b0;
                  err_d      = 1'b0;
               end
            end
            ST_SETTLE: begin
               if (state_d == ST_MEASURE) begin
                  cyc_cnt_d  = '0;
                  ones_cnt_d = '0;
               end else begin
                  cyc_cnt_d = cyc_cnt + CNT_W'(1);
               end
            end
            ST_MEASURE: begin
               ones_cnt_d = ones_cnt + ONES_W'(cmp_in);
               cyc_cnt_d  = (state_d == ST_DECIDE) ? '0 : cyc_cnt + CNT_W'(1);
            end
            ST_DECIDE: begin
               trim_d = trial_code;
               if (bit_idx != '0) begin
                  bit_idx_d = bit_idx - IDX_W'(1);
               end else begin
                  short_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  err_d   = (trial_code == '0) || (&trial_code);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_digi_ota_cal_seq.sv
// Directed bench for digi_ota_cal_seq: cycle-exact latency, SAR results for
// several comparator patterns, start/abort/reset corner cases.
module tb_digi_ota_cal_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       cmp_in;
   logic [5:0] trim_code;
   logic       short_en, busy, done, cal_err;

   int         mode = 0;
   logic [5:0] target = 6'd37;
   logic       tog = 1'b0;
   int         n_checks = 0;
   int         n_pass = 0;

   digi_ota_cal_seq #(.TRIM_W(6), .SETTLE_CYC(16), .AVG_CYC(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .cmp_in(cmp_in),
      .trim_code(trim_code), .short_en(short_en), .busy(busy), .done(done),
      .cal_err(cal_err)
   );

   always #5 clk = ~clk;
   always @(negedge clk) tog = ~tog;

   // Comparator model: 1 means the code is still too low.
   assign cmp_in = (mode == 0) ? (trim_code <= target) :
                   (mode == 1) ? 1'b1 :
                   (mode == 2) ? 1'b0 : tog;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic pulse_start(input logic with_abort);
      @(negedge clk);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Called after start was sampled at edge k and `elapsed` further edges passed.
   task automatic finish_run(input string tag, input int elapsed,
                             input logic [5:0] exp_code, input logic exp_err);
      repeat (293 - elapsed) @(negedge clk);
      check({tag, "_done_early"}, done, 0);
      @(negedge clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_short"}, short_en, 0);
      check({tag, "_code"}, trim_code, exp_code);
      check({tag, "_err"}, cal_err, exp_err);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_code", trim_code, 32);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_short", short_en, 0);
      check("rst_err", cal_err, 0);
      rst = 1'b0;

      // Asynchronous reset during MEASURE.
      mode = 0; target = 6'd37;
      pulse_start(1'b0);
      check("start_busy", busy, 1);
      check("start_short", short_en, 1);
      check("start_code", trim_code, 32);
      repeat (20) @(negedge clk);
      check("meas_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_code", trim_code, 32);
      check("arst_short", short_en, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;

      // Nominal search converging on 37.
      pulse_start(1'b0);
      finish_run("tgt37", 0, 6'd37, 1'b0);

      // Abort while DONE is ignored.
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done_lvl", done, 1);
      check("abort_done_code", trim_code, 37);

      // Rails.
      mode = 1;
      pulse_start(1'b0);
      finish_run("rail_hi", 0, 6'd63, 1'b1);
      mode = 2;
      pulse_start(1'b0);
      finish_run("rail_lo", 0, 6'd0, 1'b1);

      // Alternating comparator: every trial is a tie.
      mode = 3;
      pulse_start(1'b0);
      finish_run("tie", 0, 6'd0, 1'b1);

      // Re-start while busy is ignored.
      mode = 0; target = 6'd50;
      pulse_start(1'b0);
      repeat (98) @(negedge clk);
      pulse_start(1'b0);
      check("restart_busy", busy, 1);
      finish_run("ign_start", 100, 6'd50, 1'b0);

      // Start from DONE with abort asserted too: start wins.
      target = 6'd20;
      pulse_start(1'b1);
      check("redo_done", done, 0);
      check("redo_busy", busy, 1);
      check("redo_code", trim_code, 32);
      finish_run("redo", 0, 6'd20, 1'b0);

      // Abort mid-run.
      pulse_start(1'b0);
      repeat (148) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_code", trim_code, 32);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_short", short_en, 0);
      repeat (5) @(negedge clk);
      check("abort_idle", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
